// File: rtl/sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_renderer
//  Purpose  : Double-buffered ball-slot registers plus a 2-stage pixel
//             pipeline that composites up to NUM_BALLS circular sprites.
//             Lowest slot index wins; background colour is 0.
//  Options  : define OVERLAP_DETECT_EN to build the multi-hit flag on
//             'overlap'. Otherwise 'overlap' is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_renderer #(
    parameter int NUM_BALLS = 4,
    parameter int COLOR_W   = 8
) (
    input  logic                         clock,
    input  logic                         reset_L,
    input  logic [62:0][62:0]            sprite,
    input  logic                         frame_start,
    input  logic                         pix_valid,
    input  logic [9:0]                   row,
    input  logic [9:0]                   col,
    input  logic                         pos_valid,
    output logic                         pos_ready,
    input  logic [$clog2(NUM_BALLS)-1:0] pos_id,
    input  logic [9:0]                   pos_x,
    input  logic [9:0]                   pos_y,
    input  logic [COLOR_W-1:0]           pos_color,
    input  logic                         pos_en,
    output logic [COLOR_W-1:0]           pix_out,
    output logic                         pix_out_valid,
    output logic                         overlap
);

    localparam int ID_W = $clog2(NUM_BALLS);
    localparam logic [10:0] C_BOX_MAX = 11'd62;

    // Shadow (written by updates) and active (used for rendering) slot sets
    logic [9:0]         r_sh_x     [NUM_BALLS];
    logic [9:0]         r_sh_y     [NUM_BALLS];
    logic [COLOR_W-1:0] r_sh_color [NUM_BALLS];
    logic               r_sh_en    [NUM_BALLS];
    logic [9:0]         r_act_x    [NUM_BALLS];
    logic [9:0]         r_act_y    [NUM_BALLS];
    logic [COLOR_W-1:0] r_act_color[NUM_BALLS];
    logic               r_act_en   [NUM_BALLS];

    logic               r_rdy_en;
    logic               w_accept;

    // Stage-1 results, captured together with the slot colour so a commit
    // between the stages cannot change the colour of an in-flight pixel
    logic [10:0]        w_dx       [NUM_BALLS];
    logic [10:0]        w_dy       [NUM_BALLS];
    logic [NUM_BALLS-1:0] w_inbox;
    logic               r_s1_valid;
    logic [NUM_BALLS-1:0] r_s1_inbox;
    logic [5:0]         r_s1_dx    [NUM_BALLS];
    logic [5:0]         r_s1_dy    [NUM_BALLS];
    logic [COLOR_W-1:0] r_s1_color [NUM_BALLS];

    logic [NUM_BALLS-1:0] w_hit;
    logic [COLOR_W-1:0] w_sel_color;
    logic [COLOR_W-1:0] r_pix;
    logic               r_pix_valid;

    // Readiness comes up on the first edge after reset; commit cycles block updates
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) r_rdy_en <= 1'b0;
        else          r_rdy_en <= 1'b1;
    end

    assign pos_ready = r_rdy_en & ~frame_start;
    assign w_accept  = pos_valid & pos_ready;

    // Shadow write; an out-of-range pos_id matches no slot and is dropped
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                r_sh_x[i]     <= '0;
                r_sh_y[i]     <= '0;
                r_sh_color[i] <= '0;
                r_sh_en[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                if (w_accept && (pos_id == i[ID_W-1:0])) begin
                    r_sh_x[i]     <= pos_x;
                    r_sh_y[i]     <= pos_y;
                    r_sh_color[i] <= pos_color;
                    r_sh_en[i]    <= pos_en;
                end
            end
        end
    end

    // Snapshot every shadow set into the active set at frame start
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                r_act_x[i]     <= '0;
                r_act_y[i]     <= '0;
                r_act_color[i] <= '0;
                r_act_en[i]    <= 1'b0;
            end
        end else if (frame_start) begin
            for (int i = 0; i < NUM_BALLS; i++) begin
                r_act_x[i]     <= r_sh_x[i];
                r_act_y[i]     <= r_sh_y[i];
                r_act_color[i] <= r_sh_color[i];
                r_act_en[i]    <= r_sh_en[i];
            end
        end
    end

    // Box offsets; a borrow sets bit 10, which also pushes the value past 62
    always_comb begin
        for (int i = 0; i < NUM_BALLS; i++) begin
            w_dx[i]    = {1'b0, col} - {1'b0, r_act_x[i]};
            w_dy[i]    = {1'b0, row} - {1'b0, r_act_y[i]};
            w_inbox[i] = r_act_en[i] && !w_dx[i][10] && !w_dy[i][10]
                         && (w_dx[i] <= C_BOX_MAX) && (w_dy[i] <= C_BOX_MAX);
        end
    end

    // Stage 1 register: per-slot box test, offsets and colour
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_s1_valid <= 1'b0;
            r_s1_inbox <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                r_s1_dx[i]    <= '0;
                r_s1_dy[i]    <= '0;
                r_s1_color[i] <= '0;
            end
        end else begin
            r_s1_valid <= pix_valid;
            r_s1_inbox <= pix_valid ? w_inbox : '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                r_s1_dx[i]    <= w_dx[i][5:0];
                r_s1_dy[i]    <= w_dy[i][5:0];
                r_s1_color[i] <= r_act_color[i];
            end
        end
    end

    // Mask lookup and lowest-index priority select (scan high to low, last wins)
    always_comb begin
        w_sel_color = '0;
        w_hit       = '0;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            w_hit[i] = r_s1_inbox[i] & sprite[r_s1_dy[i]][r_s1_dx[i]];
            if (w_hit[i]) w_sel_color = r_s1_color[i];
        end
    end

    // Stage 2 register: colour forced to background when no pixel is valid
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            r_pix       <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix       <= r_s1_valid ? w_sel_color : '0;
            r_pix_valid <= r_s1_valid;
        end
    end

    assign pix_out       = r_pix;
    assign pix_out_valid = r_pix_valid;

`ifdef OVERLAP_DETECT_EN
    logic w_any;
    logic w_multi;
    logic r_overlap;

    // Two-or-more detector: a hit seen after an earlier hit flags overlap
    always_comb begin
        w_any   = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            w_multi = w_multi | (w_any & w_hit[i]);
            w_any   = w_any | w_hit[i];
        end
    end

    // Overlap flag registered alongside pix_out
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) r_overlap <= 1'b0;
        else          r_overlap <= r_s1_valid & w_multi;
    end

    assign overlap = r_overlap;
`else
    assign overlap = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sprite_renderer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_renderer
//  Purpose  : Self-checking bench for sprite_renderer (table-driven pixel
//             vectors plus hand-written commit / handshake / reset sequences).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_renderer;

`ifdef OVERLAP_DETECT_EN
    localparam bit OV_ON = 1'b1;
`else
    localparam bit OV_ON = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_L = 1'b0;
    logic [62:0][62:0] sprite;
    logic              frame_start = 1'b0;
    logic              pix_valid = 1'b0;
    logic [9:0]        row = '0;
    logic [9:0]        col = '0;
    logic              pos_valid = 1'b0;
    logic              pos_ready;
    logic [1:0]        pos_id = '0;
    logic [9:0]        pos_x = '0;
    logic [9:0]        pos_y = '0;
    logic [7:0]        pos_color = '0;
    logic              pos_en = 1'b0;
    logic [7:0]        pix_out;
    logic              pix_out_valid;
    logic              overlap;

    sprite_renderer #(.NUM_BALLS(4), .COLOR_W(8)) dut (
        .clock(clock), .reset_L(reset_L), .sprite(sprite),
        .frame_start(frame_start), .pix_valid(pix_valid), .row(row), .col(col),
        .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_id(pos_id),
        .pos_x(pos_x), .pos_y(pos_y), .pos_color(pos_color), .pos_en(pos_en),
        .pix_out(pix_out), .pix_out_valid(pix_out_valid), .overlap(overlap)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0] r;
        logic [9:0] c;
        logic [7:0] pix;
        logic       ov;
    } vec_t;

    vec_t vecs[16];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic write_slot(input logic [1:0] id, input logic [9:0] x, input logic [9:0] y,
                              input logic [7:0] c, input logic en);
        @(negedge clock);
        pos_valid = 1'b1; pos_id = id; pos_x = x; pos_y = y; pos_color = c; pos_en = en;
        @(negedge clock);
        pos_valid = 1'b0;
    endtask

    task automatic commit();
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
    endtask

    // Stream vectors lo..hi back-to-back; each output checked 2 cycles later
    task automatic run_vecs(input int lo, input int hi);
        for (int k = lo; k <= hi + 2; k++) begin
            @(negedge clock);
            if (k == lo + 1) check($sformatf("latency_v%0d", lo), {31'd0, pix_out_valid}, 32'd0);
            if (k - 2 >= lo) begin
                check($sformatf("valid_v%0d", k - 2), {31'd0, pix_out_valid}, 32'd1);
                check($sformatf("pix_v%0d", k - 2), {24'd0, pix_out}, {24'd0, vecs[k-2].pix});
                check($sformatf("ov_v%0d", k - 2), {31'd0, overlap}, {31'd0, vecs[k-2].ov & OV_ON});
            end
            if (k <= hi) begin
                pix_valid = 1'b1; row = vecs[k].r; col = vecs[k].c;
            end else begin
                pix_valid = 1'b0;
            end
        end
        @(negedge clock);
        check($sformatf("drain_v%0d", hi), {24'd0, pix_out, 7'd0, pix_out_valid}, 32'd0);
    endtask

    initial begin
        // Circle mask of radius 31 centred in the 63x63 box
        for (int r = 0; r < 63; r++)
            for (int c = 0; c < 63; c++)
                sprite[r][c] = ((r - 31) * (r - 31) + (c - 31) * (c - 31)) <= 961;

        vecs[0]  = '{10'd81,  10'd131, 8'hE0, 1'b0};
        vecs[1]  = '{10'd50,  10'd100, 8'h00, 1'b0};
        vecs[2]  = '{10'd81,  10'd331, 8'h00, 1'b0};
        vecs[3]  = '{10'd81,  10'd131, 8'hE0, 1'b0};
        vecs[4]  = '{10'd81,  10'd131, 8'h00, 1'b0};
        vecs[5]  = '{10'd81,  10'd331, 8'hE0, 1'b0};
        vecs[6]  = '{10'd231, 10'd231, 8'h1C, 1'b1};
        vecs[7]  = '{10'd200, 10'd200, 8'h00, 1'b0};
        vecs[8]  = '{10'd81,  10'd331, 8'h00, 1'b0};
        vecs[9]  = '{10'd31,  10'd639, 8'h5A, 1'b0};
        vecs[10] = '{10'd31,  10'd5,   8'h00, 1'b0};
        vecs[11] = '{10'd31,  10'd619, 8'h00, 1'b0};
        vecs[12] = '{10'd41,  10'd41,  8'h00, 1'b0};
        vecs[13] = '{10'd41,  10'd41,  8'h77, 1'b0};
        vecs[14] = '{10'd231, 10'd231, 8'h00, 1'b0};
        vecs[15] = '{10'd41,  10'd41,  8'h00, 1'b0};

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_pix",   {24'd0, pix_out}, 32'd0);
        check("rst_valid", {31'd0, pix_out_valid}, 32'd0);
        check("rst_ov",    {31'd0, overlap}, 32'd0);
        check("rst_ready", {31'd0, pos_ready}, 32'd0);
        reset_L = 1'b1;
        @(negedge clock);
        check("ready_after_rst", {31'd0, pos_ready}, 32'd1);

        // Basic render, then shadow write without commit, then commit
        write_slot(2'd0, 10'd100, 10'd50, 8'hE0, 1'b1);
        commit();
        run_vecs(0, 2);
        write_slot(2'd0, 10'd300, 10'd50, 8'hE0, 1'b1);
        run_vecs(3, 3);
        commit();
        run_vecs(4, 5);

        // Two coincident balls: lowest index wins
        write_slot(2'd0, 10'd200, 10'd200, 8'h1C, 1'b1);
        write_slot(2'd1, 10'd200, 10'd200, 8'h03, 1'b1);
        commit();
        run_vecs(6, 8);

        // Right-edge ball, no wrap
        write_slot(2'd2, 10'd620, 10'd0, 8'h5A, 1'b1);
        commit();
        run_vecs(9, 11);

        // Write during frame_start is refused; retry afterwards is accepted
        @(negedge clock);
        frame_start = 1'b1;
        pos_valid = 1'b1; pos_id = 2'd3; pos_x = 10'd10; pos_y = 10'd10;
        pos_color = 8'h77; pos_en = 1'b1;
        #1 check("ready_in_commit", {31'd0, pos_ready}, 32'd0);
        @(negedge clock);
        frame_start = 1'b0; pos_valid = 1'b0;
        commit();
        run_vecs(12, 12);
        write_slot(2'd3, 10'd10, 10'd10, 8'h77, 1'b1);
        commit();
        run_vecs(13, 13);

        // Pixel coincident with frame_start uses the pre-commit snapshot
        write_slot(2'd0, 10'd200, 10'd200, 8'h1C, 1'b0);
        @(negedge clock);
        frame_start = 1'b1; pix_valid = 1'b1; row = 10'd231; col = 10'd231;
        @(negedge clock);
        frame_start = 1'b0;
        @(negedge clock);
        pix_valid = 1'b0;
        check("precommit_pix", {24'd0, pix_out}, 32'h1C);
        check("precommit_ov",  {31'd0, overlap}, {31'd0, OV_ON});
        @(negedge clock);
        check("postcommit_pix", {24'd0, pix_out}, 32'h03);
        check("postcommit_ov",  {31'd0, overlap}, 32'd0);

        // Reset with pixels in flight
        @(negedge clock);
        pix_valid = 1'b1; row = 10'd231; col = 10'd231;
        repeat (2) @(negedge clock);
        check("pre_rst_valid", {31'd0, pix_out_valid}, 32'd1);
        reset_L = 1'b0;
        #1;
        check("midrst_pix",   {24'd0, pix_out}, 32'd0);
        check("midrst_valid", {31'd0, pix_out_valid}, 32'd0);
        check("midrst_ready", {31'd0, pos_ready}, 32'd0);
        pix_valid = 1'b0;
        @(negedge clock);
        reset_L = 1'b1;
        @(negedge clock);
        check("flush_valid", {31'd0, pix_out_valid}, 32'd0);
        commit();
        run_vecs(14, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
